int8_pe_datapath: RTL and testbench
===================================

# int8_pe_datapath

Per-pixel INT8 convolution datapath for the DPU. It holds three independent, registered compute stages on one clock: an INT8×INT8 multiply-accumulate into a 32-bit accumulator, a LeakyReLU on the 32-bit biased sum, and a fixed-point requantizer back to INT8. The sequencer outside the block chains the stages (MAC result, plus bias, then LeakyReLU, then requantize) to produce each output-channel value of a 3×3 convolution layer.

## Interface
Parameters:
- `ACC_W`, 32: accumulator, LeakyReLU and requantizer input width.
- `SCALE_Q`, 16: number of fractional bits in `req_scale`.
- `LEAKY_SHIFT`, 3: negative-slope shift; the slope is 2^-LEAKY_SHIFT.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mac_valid` in 1: MAC operand strobe.
- `mac_weight` in 8: signed weight.
- `mac_activation` in 8: signed activation.
- `mac_acc_in` in ACC_W: signed accumulator input.
- `mac_acc_out` out ACC_W: signed accumulator result.
- `mac_done` out 1: MAC result-valid pulse.
- `leaky_valid` in 1: LeakyReLU input strobe.
- `leaky_x` in ACC_W: signed input value.
- `leaky_y` out ACC_W: signed activated output.
- `leaky_done` out 1: LeakyReLU result-valid pulse.
- `req_valid` in 1: requantize input strobe.
- `req_acc` in ACC_W: signed input value.
- `req_scale` in 16: unsigned scale in Q(SCALE_Q) format; 655 ≈ 0.01.
- `req_out` out 8: signed saturated INT8 result.
- `req_done` out 1: requantize result-valid pulse.

## Operation
- The three stages are fully independent and may be strobed in the same cycle.
- MAC: `mac_acc_out` = `mac_acc_in` + `mac_weight`×`mac_activation`.
  - The product is 16-bit signed, sign-extended before the add.
  - The sum wraps modulo 2^ACC_W; there is no saturation.
- LeakyReLU:
  - If `leaky_x` ≥ 0, `leaky_y` = `leaky_x`.
  - Otherwise `leaky_y` = `leaky_x` >>> LEAKY_SHIFT, an arithmetic shift that floors toward −∞.
- Requantize:
  - p = `req_acc` × zero-extended `req_scale`, computed at ACC_W+17 bits signed.
  - q = p >>> SCALE_Q, floored, or rounded per Configuration.
  - `req_out` = q clamped to [−128, 127].
- Outputs hold their last value while the stage's valid is low.

## Timing
- Every stage has a latency of 1 cycle: inputs are sampled on the edge where valid=1, and the result is registered on that same edge.
- `*_done` is a registered copy of the stage's valid: high for exactly the cycle after each accepted strobe.
- Back-to-back valids are each accepted, one per cycle; `done` then stays high continuously.
- There is no backpressure and no ready signal. The caller may drive the next MAC with `mac_acc_in` = previous `mac_acc_out` from the cycle after `mac_done`.
- Reset values: all data outputs are 0 and all `done` outputs are 0.
- Reset is asynchronous. Asserting it mid-operation clears every register immediately and drops any in-flight result; no `done` is produced for it.
- The first valid after reset release is accepted normally.

## Configuration
- Macro `REQ_ROUND_EN`.
- Defined: add 2^(SCALE_Q−1) to p before the shift, giving round-half-up.
- Undefined: plain arithmetic-shift truncation, i.e. floor.
- Saturation is applied in both cases.

## Structure
- Package `int8_pe_pkg`: `ACC_W`, `SCALE_Q` default, the INT8_MIN and INT8_MAX constants, and typedefs `acc_t` (signed ACC_W) and `int8_t`.
- One sub-module, `sat_int8`: a combinational clamp of a wide signed value to INT8, used by the requantize stage.
- The MAC and LeakyReLU stages are inline `always_ff` blocks.

## Test plan
- Reset: assert `rst_n` low with random inputs. All outputs must read 0; mid-stream reset clears `mac_acc_out` to 0 without waiting for a clock.
- MAC basic and wrap:
  - acc_in=100, w=−3, a=5 → 85, with `mac_done` high for one cycle.
  - acc_in=0x7FFFFFFF, w=1, a=1 → 0x80000000.
  - w=−128, a=−128, acc_in=0 → 16384.
- MAC chain: 576 MACs with feedback, all w=127 and a=127 → 9,290,304; and random w/a → equal to the software dot product.
- LeakyReLU:
  - 1000 → 1000.
  - 0 → 0.
  - −100 → −13.
  - −1 → −1.
  - −8 → −1.
  - 0x80000000 → 0xF0000000.
- Requantize with scale=655:
  - 10000 → 99, or 100 with `REQ_ROUND_EN`.
  - −10000 → −100.
  - 20000 → 127.
  - −20000 → −128.
  - scale=0 → 0.
- End-to-end: for each of 4 channels, 576 MACs, then +bias, then LeakyReLU, then requantize. Each result must match the golden INT8, and strobing all three stages in the same cycle must give independent, correct results.

Source files
------------

// File: rtl/int8_pe_pkg.sv
// int8_pe_pkg: shared widths, INT8 limits and types for the INT8 PE datapath.
// Contents: ACC_W, SCALE_Q defaults, INT8_MIN/INT8_MAX, acc_t, int8_t.
package int8_pe_pkg;

    localparam int ACC_W    = 32;
    localparam int SCALE_Q  = 16;
    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [7:0]       int8_t;

endpackage

// File: rtl/int8_pe_datapath_sat_int8.sv
// sat_int8: combinational clamp of a W-bit signed value to [-128, 127].
// Ports: din (W-bit signed) in, dout (8-bit signed) out.
module sat_int8
    import int8_pe_pkg::*;
#(
    parameter int W = 49
) (
    input  logic signed [W-1:0] din,
    output int8_t               dout
);

    localparam logic signed [W-1:0] HI = W'(INT8_MAX);
    localparam logic signed [W-1:0] LO = W'(INT8_MIN);

    always_comb begin
        dout = din[7:0];
        if (din > HI) begin
            dout = 8'(INT8_MAX);
        end else if (din < LO) begin
            dout = 8'(INT8_MIN);
        end
    end

endmodule

// File: rtl/int8_pe_datapath.sv
// int8_pe_datapath: three independent 1-cycle stages - INT8 MAC into ACC_W,
// LeakyReLU (slope 2^-LEAKY_SHIFT), and Q(SCALE_Q) requantize to INT8.
// Ports: clk, rst_n (async, active-low); mac_valid/weight/activation/acc_in ->
// mac_acc_out/mac_done; leaky_valid/x -> leaky_y/leaky_done;
// req_valid/acc/scale -> req_out/req_done.
// Build option: define REQ_ROUND_EN for round-half-up requantize (else floor).
module int8_pe_datapath
    import int8_pe_pkg::*;
#(
    parameter int ACC_W       = int8_pe_pkg::ACC_W,
    parameter int SCALE_Q     = int8_pe_pkg::SCALE_Q,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mac_valid,
    input  logic [7:0]       mac_weight,
    input  logic [7:0]       mac_activation,
    input  logic [ACC_W-1:0] mac_acc_in,
    output logic [ACC_W-1:0] mac_acc_out,
    output logic             mac_done,
    input  logic             leaky_valid,
    input  logic [ACC_W-1:0] leaky_x,
    output logic [ACC_W-1:0] leaky_y,
    output logic             leaky_done,
    input  logic             req_valid,
    input  logic [ACC_W-1:0] req_acc,
    input  logic [15:0]      req_scale,
    output logic [7:0]       req_out,
    output logic             req_done
);

    // Product width: ACC_W signed times 17-bit (zero-extended) scale.
    localparam int PW = ACC_W + 17;

    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] lx;
    logic signed [ACC_W-1:0] lneg;
    logic signed [PW-1:0]    p;
    logic signed [PW-1:0]    pr;
    logic signed [PW-1:0]    q;
    int8_t                   q_sat;

    assign prod = 16'($signed(mac_weight)) * 16'($signed(mac_activation));

    assign lx   = leaky_x;
    assign lneg = lx >>> LEAKY_SHIFT;

    assign p = PW'($signed(req_acc)) * PW'($signed({1'b0, req_scale}));

`ifdef REQ_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (SCALE_Q - 1);
    assign pr = p + HALF;
`else
    assign pr = p;
`endif

    assign q = pr >>> SCALE_Q;

    sat_int8 #(
        .W    (PW)
    ) u_sat (
        .din  (q),
        .dout (q_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_acc_out <= '0;
            mac_done    <= 1'b0;
        end else begin
            mac_done <= mac_valid;
            if (mac_valid) begin
                // Sum wraps modulo 2^ACC_W by design.
                mac_acc_out <= mac_acc_in
                             + {{(ACC_W-16){prod[15]}}, prod};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaky_y    <= '0;
            leaky_done <= 1'b0;
        end else begin
            leaky_done <= leaky_valid;
            if (leaky_valid) begin
                leaky_y <= lx[ACC_W-1] ? lneg : lx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_out  <= '0;
            req_done <= 1'b0;
        end else begin
            req_done <= req_valid;
            if (req_valid) begin
                req_out <= q_sat;
            end
        end
    end

endmodule

// File: tb/tb_int8_pe_datapath.sv
// tb_int8_pe_datapath: directed self-checking bench for int8_pe_datapath.
// Drives inputs on negedge, samples outputs on the following negedge.
module tb_int8_pe_datapath;

    logic        clk;
    logic        rst_n;
    logic        mac_valid;
    logic [7:0]  mac_weight;
    logic [7:0]  mac_activation;
    logic [31:0] mac_acc_in;
    logic [31:0] mac_acc_out;
    logic        mac_done;
    logic        leaky_valid;
    logic [31:0] leaky_x;
    logic [31:0] leaky_y;
    logic        leaky_done;
    logic        req_valid;
    logic [31:0] req_acc;
    logic [15:0] req_scale;
    logic [7:0]  req_out;
    logic        req_done;

    int checks = 0;
    int errors = 0;

    int8_pe_datapath dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mac_valid      (mac_valid),
        .mac_weight     (mac_weight),
        .mac_activation (mac_activation),
        .mac_acc_in     (mac_acc_in),
        .mac_acc_out    (mac_acc_out),
        .mac_done       (mac_done),
        .leaky_valid    (leaky_valid),
        .leaky_x        (leaky_x),
        .leaky_y        (leaky_y),
        .leaky_done     (leaky_done),
        .req_valid      (req_valid),
        .req_acc        (req_acc),
        .req_scale      (req_scale),
        .req_out        (req_out),
        .req_done       (req_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] sx8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic int leaky_model(input int x);
        longint lx;
        lx = x;
        if (lx >= 0) return x;
        return int'((lx - 7) / 8);
    endfunction

    function automatic int req_model(input int acc, input int scale);
        longint p;
        longint q;
        p = longint'(acc) * longint'(scale);
`ifdef REQ_ROUND_EN
        p = p + 32768;
`endif
        if (p >= 0) q = p / 65536;
        else q = -((-p + 65535) / 65536);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic mac_once(input int w, input int a, input logic [31:0] acc);
        @(negedge clk);
        mac_valid      = 1'b1;
        mac_weight     = 8'(w);
        mac_activation = 8'(a);
        mac_acc_in     = acc;
        @(negedge clk);
        mac_valid = 1'b0;
    endtask

    task automatic mac_stream(input int n, input bit rnd, output int dot);
        int w;
        int a;
        dot = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w = rnd ? int'($urandom_range(255)) - 128 : 127;
            a = rnd ? int'($urandom_range(255)) - 128 : 127;
            mac_valid      = 1'b1;
            mac_weight     = 8'(w);
            mac_activation = 8'(a);
            mac_acc_in     = (i == 0) ? 32'd0 : mac_acc_out;
            dot            = dot + w * a;
        end
        @(negedge clk);
        mac_valid = 1'b0;
    endtask

    task automatic leaky_once(input logic [31:0] x);
        @(negedge clk);
        leaky_valid = 1'b1;
        leaky_x     = x;
        @(negedge clk);
        leaky_valid = 1'b0;
    endtask

    task automatic req_once(input logic [31:0] acc, input logic [15:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_acc   = acc;
        req_scale = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int dot;
        int bias;
        int x;
        int ly;
        int e100;
        logic [31:0] xv [6];
        logic [31:0] yv [6];

        rst_n          = 1'b0;
        mac_valid      = 1'b1;
        mac_weight     = 8'($urandom);
        mac_activation = 8'($urandom);
        mac_acc_in     = $urandom;
        leaky_valid    = 1'b1;
        leaky_x        = $urandom;
        req_valid      = 1'b1;
        req_acc        = $urandom;
        req_scale      = 16'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_mac_acc", mac_acc_out, 32'd0);
        chk("rst_mac_done", 32'(mac_done), 32'd0);
        chk("rst_leaky_y", leaky_y, 32'd0);
        chk("rst_leaky_done", 32'(leaky_done), 32'd0);
        chk("rst_req_out", 32'(req_out), 32'd0);
        chk("rst_req_done", 32'(req_done), 32'd0);
        mac_valid   = 1'b0;
        leaky_valid = 1'b0;
        req_valid   = 1'b0;
        rst_n       = 1'b1;

        mac_once(-3, 5, 32'd100);
        chk("mac_basic", mac_acc_out, 32'd85);
        chk("mac_basic_done", 32'(mac_done), 32'd1);
        @(negedge clk);
        chk("mac_done_pulse", 32'(mac_done), 32'd0);
        chk("mac_hold", mac_acc_out, 32'd85);

        @(negedge clk);
        mac_valid      = 1'b1;
        mac_weight     = 8'd7;
        mac_activation = 8'd9;
        mac_acc_in     = 32'd1000;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_acc", mac_acc_out, 32'd0);
        @(posedge clk);
        #1 chk("rst_hold_acc", mac_acc_out, 32'd0);
        @(negedge clk);
        mac_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("rst_no_done", 32'(mac_done), 32'd0);
        chk("rst_drop_acc", mac_acc_out, 32'd0);

        mac_once(1, 1, 32'h7FFF_FFFF);
        chk("mac_wrap", mac_acc_out, 32'h8000_0000);
        mac_once(-128, -128, 32'd0);
        chk("mac_minmin", mac_acc_out, 32'd16384);

        mac_stream(576, 1'b0, dot);
        chk("mac_chain_127", mac_acc_out, 32'd9290304);
        chk("mac_chain_done", 32'(mac_done), 32'd1);
        mac_stream(576, 1'b1, dot);
        chk("mac_chain_rand", mac_acc_out, 32'(dot));

        xv = '{32'd1000, 32'd0, -32'sd100, -32'sd1, -32'sd8, 32'h8000_0000};
        yv = '{32'd1000, 32'd0, -32'sd13, -32'sd1, -32'sd1, 32'hF000_0000};
        for (int i = 0; i < 6; i++) begin
            leaky_once(xv[i]);
            chk($sformatf("leaky_%0d", i), leaky_y, yv[i]);
        end
        chk("leaky_done", 32'(leaky_done), 32'd1);

`ifdef REQ_ROUND_EN
        e100 = 100;
`else
        e100 = 99;
`endif
        req_once(32'd10000, 16'd655);
        chk("req_10000", sx8(req_out), 32'(e100));
        chk("req_done", 32'(req_done), 32'd1);
        req_once(-32'sd10000, 16'd655);
        chk("req_m10000", sx8(req_out), -32'sd100);
        req_once(32'd20000, 16'd655);
        chk("req_sat_hi", sx8(req_out), 32'd127);
        req_once(-32'sd20000, 16'd655);
        chk("req_sat_lo", sx8(req_out), -32'sd128);
        req_once(32'd12345, 16'd0);
        chk("req_scale0", sx8(req_out), 32'd0);

        for (int ch = 0; ch < 4; ch++) begin
            mac_stream(576, 1'b1, dot);
            chk($sformatf("e2e_dot_%0d", ch), mac_acc_out, 32'(dot));
            bias = int'($urandom_range(4000)) - 2000;
            x    = dot + bias;
            leaky_once(32'(x));
            ly = leaky_model(x);
            chk($sformatf("e2e_leaky_%0d", ch), leaky_y, 32'(ly));
            req_once(leaky_y, 16'd60);
            chk($sformatf("e2e_req_%0d", ch), sx8(req_out),
                32'(req_model(ly, 60)));
        end

        @(negedge clk);
        mac_valid      = 1'b1;
        mac_weight     = 8'(-3);
        mac_activation = 8'd5;
        mac_acc_in     = 32'd100;
        leaky_valid    = 1'b1;
        leaky_x        = -32'sd100;
        req_valid      = 1'b1;
        req_acc        = 32'd10000;
        req_scale      = 16'd655;
        @(negedge clk);
        mac_valid   = 1'b0;
        leaky_valid = 1'b0;
        req_valid   = 1'b0;
        chk("par_mac", mac_acc_out, 32'd85);
        chk("par_leaky", leaky_y, -32'sd13);
        chk("par_req", sx8(req_out), 32'(e100));
        chk("par_done", {29'd0, mac_done, leaky_done, req_done}, 32'd7);
        @(negedge clk);
        chk("par_done_off", {29'd0, mac_done, leaky_done, req_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
